clk_tick_scheduler: RTL and testbench
=====================================

Name: clk_tick_scheduler

Overview:
Shares one free-running power-of-2 prescaler counter among NCH consumers, for example display scan, key debounce and cursor blink in the calculator. Each channel is configured at run time through a valid/ready port with a tap index k. Each channel emits a one-cycle clock-enable pulse every 2^k cycles and never produces a derived clock. Reconfiguration is glitch-free: a channel re-aligns to its new tap before ticking, so no period is ever shorter than 2^k.

Parameters:
CNT_W, 36, prescaler counter width; legal taps are 0..CNT_W.
NCH, 4, number of tick channels.
TAP_W, 6, width of cfg_tap; must satisfy 2^TAP_W > CNT_W.
CH_W, 2, width of cfg_chan; must satisfy 2^CH_W >= NCH.

Ports:
CLK_in  in  1  the single system clock; all logic is on its rising edge.
RST_n  in  1  asynchronous, active-low reset.
cfg_valid  in  1  configuration request.
cfg_ready  out  1  high when a request can be accepted.
cfg_chan  in  CH_W  target channel.
cfg_tap  in  TAP_W  tap index k.
cfg_en  in  1  1 = enable the channel at tap k; 0 = disable it.
cfg_err  out  1  one-cycle pulse when a request is rejected.
tick_out  out  NCH  one-cycle enable pulse per channel.
ch_active  out  NCH  channel is in RUN.
count_out  out  CNT_W  current prescaler value.

Behaviour:
- Reset (asynchronous, RST_n low): count_out=0, tick_out=0, ch_active=0, cfg_err=0, every channel in OFF, config FSM in IDLE. All inputs are ignored while RST_n is low.
- Counter: increments by 1 every cycle and wraps from 2^CNT_W-1 to 0 with no stall.
- Boundary for tap k, evaluated on the current count C:
  - k=0: b_k=1 every cycle.
  - k>=1: b_k = (C[k-1:0] == all ones).
  - k=CNT_W: b_k is true only at the wrap.
- Config FSM, two states:
  - IDLE: cfg_ready=1 (combinational). On cfg_valid && cfg_ready, latch chan/tap/en and go to APPLY.
  - APPLY: cfg_ready=0. Return to IDLE at the next edge.
  - Sustained throughput is therefore one request per 2 cycles.
- APPLY action, taken at the edge that ends the APPLY cycle:
  - If tap > CNT_W or chan >= NCH: cfg_err=1 for the next cycle only, and no channel changes.
  - Else if en=0: the channel goes to OFF.
  - Else: store the tap and the channel goes to ARM. This applies even if the channel was already in RUN.
- Channel FSM:
  - OFF: holds; no ticks.
  - ARM: waits for b_tap. On the edge where b_tap is true, go to RUN with no tick emitted; that boundary is used only for alignment.
  - RUN: on each edge, tick_out[i] <= b_tap.
  - tick_out is registered, so a pulse appears in the cycle where count_out[tap-1:0]==0. Period is exactly 2^tap; tap 0 gives a tick every cycle.
- ch_active[i] = (state==RUN). tick_out[i]=0 in every cycle the channel is not in RUN.
- Simultaneous events:
  - APPLY targeting a RUN channel on its boundary edge: the APPLY wins, the tick for that boundary is suppressed, and the channel enters ARM/OFF.
  - Channels not targeted by the APPLY are unaffected.
- Reset asserted mid-operation clears everything immediately. A pending APPLY is discarded.

Decomposition:
- Package clk_sched_pkg:
  - ch_state_t {OFF, ARM, RUN}
  - cfg_state_t {IDLE, APPLY}
  - CNT_W_DEF=36
  - boundary helper function: (count, tap) -> b_k.
- Sub-module tick_channel: one channel's FSM, its tap register and its boundary compare; instantiated NCH times in a generate loop.
- Top level holds the counter, the config FSM and the request decode.

Test Plan:
All scenarios use CNT_W=8, NCH=4.
1. Release reset, no config -> count_out steps 0,1,2,…; tick_out=0; ch_active=0; cfg_ready=1.
2. Accept {ch0, tap=2, en=1} in cycle count_out=5 -> APPLY at 6, ARM at 7, RUN from 8; first tick_out[0] at count_out=12, then 16, 20, …; no tick at 8.
3. {ch1, tap=0, en=1} -> after ARM, tick_out[1] is high every cycle; ch0 ticks are undisturbed.
4. Request {tap=9} or {chan=3 with NCH=3} -> cfg_err high for exactly 1 cycle; ch_active and tick_out unchanged; cfg_ready drops for 1 cycle only.
5. Reconfigure ch0 (RUN, tap 2) to tap 3 while running -> no tick until alignment, then ticks only at count_out multiples of 8; no inter-tick gap below 8 cycles. Then {ch0, en=0} -> ticks stop the next cycle.
6. Tap 8 on ch2 -> tick only in the cycle count_out wraps 255->0. Pull RST_n low mid-run -> tick_out, ch_active and count_out go to 0 asynchronously, and no ticks resume without reconfiguration.

Source files
------------

// File: rtl/clk_sched_pkg.sv
// Shared types and the tap-boundary helper for the tick scheduler.
package clk_sched_pkg;

  localparam int unsigned CNT_W_DEF = 36;
  localparam int unsigned HELPER_W  = 64;

  typedef enum logic [1:0] {OFF, ARM, RUN} ch_state_t;
  typedef enum logic {IDLE, APPLY} cfg_state_t;

  // True when the low 'tap' bits of count are all ones (tap 0 is always true).
  function automatic logic boundary(input logic [HELPER_W-1:0] count,
                                    input logic [7:0] tap);
    logic [HELPER_W-1:0] mask;
    mask = (HELPER_W'(1) << tap) - HELPER_W'(1);
    return ((count & mask) == mask);
  endfunction

endpackage

// File: rtl/clk_tick_scheduler_if.sv
// Configuration request port of the tick scheduler.
interface clk_tick_scheduler_if #(
  parameter int unsigned TAP_W = 6,
  parameter int unsigned CH_W  = 2
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [TAP_W-1:0] cfg_tap;
  logic             cfg_en;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_chan, cfg_tap, cfg_en,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_chan, cfg_tap, cfg_en,
                  output cfg_ready, cfg_err);
endinterface

// File: rtl/tick_channel.sv
// One tick channel: OFF/ARM/RUN state, tap register and boundary compare.
module tick_channel
  import clk_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TAP_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] count,
  input  logic             apply,
  input  logic             apply_en,
  input  logic [TAP_W-1:0] apply_tap,
  output logic             tick,
  output logic             active
);

  ch_state_t        state, state_nxt;
  logic [TAP_W-1:0] tap, tap_nxt;
  logic             tick_nxt;
  logic             b_tap;

  assign b_tap = boundary(HELPER_W'(count), 8'(tap));

  // State, tap and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= OFF;
      tap    <= '0;
      tick   <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_nxt;
      tap    <= tap_nxt;
      tick   <= tick_nxt;
      active <= (state_nxt == RUN);
    end
  end

  // Next state; a targeted apply overrides the boundary and drops that tick.
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap;
    tick_nxt  = 1'b0;
    case (state)
      OFF: ;
      ARM: if (b_tap) state_nxt = RUN;
      RUN: tick_nxt = b_tap;
      default: state_nxt = OFF;
    endcase
    if (apply) begin
      tick_nxt = 1'b0;
      if (apply_en) begin
        state_nxt = ARM;
        tap_nxt   = apply_tap;
      end else begin
        state_nxt = OFF;
      end
    end
  end

endmodule

// File: rtl/clk_tick_scheduler.sv
// Shared prescaler counter, config FSM and per-channel clock-enable ticks.
module clk_tick_scheduler
  import clk_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned NCH   = 4,
  parameter int unsigned TAP_W = 6,
  parameter int unsigned CH_W  = 2
) (
  input  logic             CLK_in,
  input  logic             RST_n,
  clk_tick_scheduler_if.slave cfg,
  output logic [NCH-1:0]   tick_out,
  output logic [NCH-1:0]   ch_active,
  output logic [CNT_W-1:0] count_out
);

  cfg_state_t       cfg_state, cfg_state_nxt;
  logic [CH_W-1:0]  lat_chan, lat_chan_nxt;
  logic [TAP_W-1:0] lat_tap, lat_tap_nxt;
  logic             lat_en, lat_en_nxt;
  logic             err_nxt;
  logic             req_bad;
  logic [NCH-1:0]   apply_c;

  assign cfg.cfg_ready = (cfg_state == IDLE);
  assign req_bad = (32'(lat_tap) > CNT_W) || (32'(lat_chan) >= NCH);

  // Free-running prescaler, wraps naturally.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) count_out <= '0;
    else        count_out <= count_out + CNT_W'(1);
  end

  // Config FSM state, latched request and error pulse.
  always_ff @(posedge CLK_in or negedge RST_n) begin
    if (!RST_n) begin
      cfg_state   <= IDLE;
      lat_chan    <= '0;
      lat_tap     <= '0;
      lat_en      <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg_state   <= cfg_state_nxt;
      lat_chan    <= lat_chan_nxt;
      lat_tap     <= lat_tap_nxt;
      lat_en      <= lat_en_nxt;
      cfg.cfg_err <= err_nxt;
    end
  end

  // Config next state: accept in IDLE, act for one cycle in APPLY.
  always_comb begin
    cfg_state_nxt = cfg_state;
    lat_chan_nxt  = lat_chan;
    lat_tap_nxt   = lat_tap;
    lat_en_nxt    = lat_en;
    err_nxt       = 1'b0;
    case (cfg_state)
      IDLE: begin
        if (cfg.cfg_valid) begin
          cfg_state_nxt = APPLY;
          lat_chan_nxt  = cfg.cfg_chan;
          lat_tap_nxt   = cfg.cfg_tap;
          lat_en_nxt    = cfg.cfg_en;
        end
      end
      APPLY: begin
        cfg_state_nxt = IDLE;
        err_nxt       = req_bad;
      end
      default: cfg_state_nxt = IDLE;
    endcase
  end

  // One-hot apply strobe to the targeted channel for valid requests.
  always_comb begin
    apply_c = '0;
    if (cfg_state == APPLY && !req_bad) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        apply_c[i] = (32'(lat_chan) == i);
      end
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
    tick_channel #(.CNT_W(CNT_W), .TAP_W(TAP_W)) u_ch (
      .clk       (CLK_in),
      .rst_n     (RST_n),
      .count     (count_out),
      .apply     (apply_c[g]),
      .apply_en  (lat_en),
      .apply_tap (lat_tap),
      .tick      (tick_out[g]),
      .active    (ch_active[g])
    );
  end

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Directed bench for clk_tick_scheduler with CNT_W=8, NCH=4 (plus an NCH=3 copy).
module tb_clk_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tick, act;
  logic [7:0] cnt;
  logic [2:0] tick3, act3;
  logic [7:0] cnt3;
  int unsigned t;
  int total = 0;
  int bad = 0;

  clk_tick_scheduler_if #(.TAP_W(6), .CH_W(2)) cfg ();
  clk_tick_scheduler_if #(.TAP_W(6), .CH_W(2)) cfg3 ();

  clk_tick_scheduler #(.CNT_W(8), .NCH(4), .TAP_W(6), .CH_W(2)) dut (
    .CLK_in(clk), .RST_n(rst_n), .cfg(cfg),
    .tick_out(tick), .ch_active(act), .count_out(cnt));

  clk_tick_scheduler #(.CNT_W(8), .NCH(3), .TAP_W(6), .CH_W(2)) dut3 (
    .CLK_in(clk), .RST_n(rst_n), .cfg(cfg3),
    .tick_out(tick3), .ch_active(act3), .count_out(cnt3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %0h want %0h", tag, t, obs, exp);
    end
  endtask

  // Advance one cycle; t is the absolute cycle index since reset release.
  task automatic cyc();
    @(posedge clk);
    t++;
    @(negedge clk);
    chk("count", 64'(cnt), 64'(8'(t)));
  endtask

  task automatic run_to(input int unsigned target);
    while (t < target) cyc();
  endtask

  // Present a request for one cycle; returns in the APPLY cycle.
  task automatic send(input logic [1:0] ch, input logic [5:0] tp, input logic en);
    cfg.cfg_valid = 1'b1; cfg.cfg_chan = ch; cfg.cfg_tap = tp; cfg.cfg_en = en;
    chk("ready_idle", 64'(cfg.cfg_ready), 64'(1));
    cyc();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    cfg.cfg_valid = 0; cfg.cfg_chan = 0; cfg.cfg_tap = 0; cfg.cfg_en = 0;
    cfg3.cfg_valid = 0; cfg3.cfg_chan = 0; cfg3.cfg_tap = 0; cfg3.cfg_en = 0;
    t = 0;
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(cnt), 64'(0));
    chk("rst_tick", 64'(tick), 64'(0));
    chk("rst_act", 64'(act), 64'(0));
    chk("rst_err", 64'(cfg.cfg_err), 64'(0));
    rst_n = 1'b1;

    // 1: idle counting
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("idle_tick", 64'(tick), 64'(0));
      chk("idle_act", 64'(act), 64'(0));
      chk("idle_ready", 64'(cfg.cfg_ready), 64'(1));
    end

    // 2: ch0 tap 2 accepted at count 5
    run_to(5);
    send(2'd0, 6'd2, 1'b1);
    chk("apply_ready", 64'(cfg.cfg_ready), 64'(0));
    cyc();
    chk("arm_ready", 64'(cfg.cfg_ready), 64'(1));
    chk("arm_act0", 64'(act[0]), 64'(0));
    cyc();
    chk("run_act0", 64'(act[0]), 64'(1));
    chk("no_tick_at8", 64'(tick[0]), 64'(0));
    while (t < 23) begin
      cyc();
      chk("ch0_tap2", 64'(tick[0]), 64'((t % 4) == 0));
    end

    // 3: ch1 tap 0
    send(2'd1, 6'd0, 1'b1);
    chk("apply1_ready", 64'(cfg.cfg_ready), 64'(0));
    cyc();
    cyc();
    chk("ch1_act", 64'(act[1]), 64'(1));
    chk("ch1_align", 64'(tick[1]), 64'(0));
    while (t < 35) begin
      cyc();
      chk("ch1_tap0", 64'(tick[1]), 64'(1));
      chk("ch0_undist", 64'(tick[0]), 64'((t % 4) == 0));
    end

    // 4: rejected requests (tap 9 here, chan 3 on the NCH=3 copy)
    cfg3.cfg_valid = 1'b1; cfg3.cfg_chan = 2'd3; cfg3.cfg_tap = 6'd1; cfg3.cfg_en = 1'b1;
    send(2'd0, 6'd9, 1'b1);
    cfg3.cfg_valid = 1'b0;
    chk("bad_ready", 64'(cfg.cfg_ready), 64'(0));
    chk("bad_err_early", 64'(cfg.cfg_err), 64'(0));
    cyc();
    chk("bad_tap_err", 64'(cfg.cfg_err), 64'(1));
    chk("bad_chan_err", 64'(cfg3.cfg_err), 64'(1));
    chk("bad_ready_back", 64'(cfg.cfg_ready), 64'(1));
    chk("bad_act", 64'(act), 64'(4'b0011));
    chk("bad_act3", 64'(act3), 64'(0));
    chk("bad_tick", 64'(tick), 64'(4'b0010));
    cyc();
    chk("err_one_cycle", 64'(cfg.cfg_err), 64'(0));
    chk("err3_one_cycle", 64'(cfg3.cfg_err), 64'(0));
    while (t < 41) begin
      cyc();
      chk("ch0_after_err", 64'(tick[0]), 64'((t % 4) == 0));
    end

    // 5: retap ch0 to 3 with APPLY on its boundary (count 43)
    run_to(42);
    send(2'd0, 6'd3, 1'b1);
    chk("retap_apply_tick", 64'(tick[0]), 64'(0));
    while (t < 78) begin
      cyc();
      chk("retap_tick", 64'(tick[0]), 64'(t >= 56 && (t % 8) == 0));
      chk("retap_act", 64'(act[0]), 64'(t >= 48));
      chk("retap_ch1", 64'(tick[1]), 64'(1));
    end
    send(2'd0, 6'd3, 1'b0);
    while (t < 90) begin
      cyc();
      chk("off_tick", 64'(tick[0]), 64'(0));
      chk("off_act", 64'(act[0]), 64'(0));
    end

    // 6: ch2 tap 8 ticks only at the wrap
    send(2'd2, 6'd8, 1'b1);
    while (t < 520) begin
      cyc();
      chk("tap8_tick", 64'(tick[2]), 64'(t == 512));
      chk("tap8_act", 64'(act[2]), 64'(t >= 256));
    end
    chk("pre_rst_tick", 64'(tick), 64'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 64'(cnt), 64'(0));
    chk("async_tick", 64'(tick), 64'(0));
    chk("async_act", 64'(act), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("post_rst_tick", 64'(tick), 64'(0));
      chk("post_rst_act", 64'(act), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
